// File: rtl/button_move_pulser.sv
// rtl/button_move_pulser.sv - debounced one-hot move pulses with auto-repeat for four buttons
module button_move_pulser #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int CNT_W           = 26
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic [3:0] buttons,
  output logic [3:0] move_pulse,
  output logic [3:0] btn_held
);

  typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, REPEAT, DB_REL} state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [3:0]       sync_a, sync_b;
  state_t           state    [4];
  state_t           state_nx [4];
  logic [CNT_W-1:0] cnt      [4];
  logic [CNT_W-1:0] cnt_nx   [4];
  logic [3:0]       fire, grant, held_nx;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i] + CNT_W'(1);
      fire[i]     = 1'b0;
      case (state[i])
        IDLE: begin
          cnt_nx[i] = '0;
          if (sync_b[i]) state_nx[i] = DB_PRESS;
        end
        DB_PRESS: begin
          if (!sync_b[i]) begin
            state_nx[i] = IDLE;
            cnt_nx[i]   = '0;
          end else if (cnt[i] == DB_LAST) begin
            state_nx[i] = HELD;
            fire[i]     = 1'b1;
            cnt_nx[i]   = '0;
          end
        end
        HELD: begin
          if (!sync_b[i]) begin
            state_nx[i] = DB_REL;
            cnt_nx[i]   = '0;
          end else if (cnt[i] == HOLD_LAST) begin
            state_nx[i] = REPEAT;
            fire[i]     = 1'b1;
            cnt_nx[i]   = '0;
          end
        end
        REPEAT: begin
          if (!sync_b[i]) begin
            state_nx[i] = DB_REL;
            cnt_nx[i]   = '0;
          end else if (cnt[i] == REP_LAST) begin
            fire[i]   = 1'b1;
            cnt_nx[i] = '0;
          end
        end
        DB_REL: begin
          // A bounce back high re-arms the full hold delay without firing.
          if (sync_b[i]) begin
            state_nx[i] = HELD;
            cnt_nx[i]   = '0;
          end else if (cnt[i] == DB_LAST) begin
            state_nx[i] = IDLE;
            cnt_nx[i]   = '0;
          end
        end
        default: begin
          state_nx[i] = IDLE;
          cnt_nx[i]   = '0;
        end
      endcase
      held_nx[i] = (state_nx[i] == HELD) || (state_nx[i] == REPEAT) || (state_nx[i] == DB_REL);
    end
    // Keep only the lowest-index fire; the others are dropped.
    grant = fire & (~fire + 4'd1);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_a     <= '0;
      sync_b     <= '0;
      move_pulse <= '0;
      btn_held   <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync_a     <= buttons;
      sync_b     <= sync_a;
      move_pulse <= grant;
      btn_held   <= held_nx;
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_button_move_pulser.sv
// tb/tb_button_move_pulser.sv - randomized and directed bench for button_move_pulser
module tb_button_move_pulser;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] buttons = 4'b0;
  logic [3:0] move_pulse, btn_held;

  int checks = 0;
  int errors = 0;

  button_move_pulser #(
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CNT_W(8)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .buttons(buttons),
    .move_pulse(move_pulse), .btn_held(btn_held)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  // Reference model: run lengths of the synchronized level and absolute deadlines.
  logic [3:0] m_s1, m_s2, exp_pulse, exp_held;
  bit         m_deb [4];
  int         m_hi [4], m_lo [4], m_next [4];
  int         m_e = 0;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; exp_pulse = '0; exp_held = '0;
    for (int i = 0; i < 4; i++) begin
      m_deb[i] = 0; m_hi[i] = 0; m_lo[i] = 0; m_next[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [3:0] s, f;
    s = m_s2; m_s2 = m_s1; m_s1 = buttons;
    m_e++;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      if (!m_deb[i]) begin
        if (s[i]) begin
          m_hi[i]++;
          if (m_hi[i] == D + 1) begin
            f[i] = 1'b1; m_deb[i] = 1; m_hi[i] = 0; m_lo[i] = 0; m_next[i] = m_e + H;
          end
        end else m_hi[i] = 0;
      end else if (s[i]) begin
        if (m_lo[i] > 0) begin
          m_lo[i] = 0; m_next[i] = m_e + H;
        end else if (m_e == m_next[i]) begin
          f[i] = 1'b1; m_next[i] = m_e + R;
        end
      end else begin
        m_lo[i]++;
        if (m_lo[i] == D + 1) begin
          m_deb[i] = 0; m_lo[i] = 0;
        end
      end
      exp_held[i] = m_deb[i];
    end
    exp_pulse = '0;
    for (int i = 3; i >= 0; i--) if (f[i]) exp_pulse = 4'b0001 << i;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; buttons = 4'b0;
    model_reset();
    repeat (3) @(negedge clk_in);
    checks++;
    if (move_pulse !== 4'b0 || btn_held !== 4'b0) begin
      errors++;
      $display("FAIL reset pulse=%b held=%b expected 0000/0000", move_pulse, btn_held);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_press();
    buttons = 4'b0001;
    for (int k = 1; k <= 30; k++) begin
      if (k == 11) buttons = 4'b0;
      tick();
      checks++;
      if (move_pulse !== exp_pulse || btn_held !== exp_held) begin
        errors++;
        $display("FAIL single_model k=%0d pulse=%b/%b held=%b/%b", k, move_pulse, exp_pulse, btn_held, exp_held);
      end
      checks++;
      if (move_pulse !== ((k == 7) ? 4'b0001 : 4'b0000) || btn_held !== ((k >= 7 && k <= 16) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL single_timing k=%0d pulse=%b held=%b", k, move_pulse, btn_held);
      end
    end
  endtask

  task automatic test_hold_repeat();
    int seen [$];
    int want [$];
    want = '{7, 27, 35, 43, 51, 59};
    buttons = 4'b0100;
    for (int k = 1; k <= 72; k++) begin
      if (k == 61) buttons = 4'b0;
      tick();
      if (move_pulse[2]) seen.push_back(k);
      checks++;
      if (move_pulse !== exp_pulse || btn_held !== exp_held) begin
        errors++;
        $display("FAIL hold_model k=%0d pulse=%b/%b held=%b/%b", k, move_pulse, exp_pulse, btn_held, exp_held);
      end
    end
    checks++;
    if (seen != want) begin
      errors++;
      $display("FAIL hold_edges got %p expected %p", seen, want);
    end
  endtask

  task automatic test_bounce();
    for (int k = 1; k <= 40; k++) begin
      if (k <= 20) buttons = ((k - 1) % 4 < 3) ? 4'b0010 : 4'b0000;
      else if (k <= 30) buttons = 4'b0010;
      else buttons = 4'b0;
      tick();
      checks++;
      if (move_pulse !== exp_pulse || btn_held !== exp_held) begin
        errors++;
        $display("FAIL bounce_model k=%0d pulse=%b/%b held=%b/%b", k, move_pulse, exp_pulse, btn_held, exp_held);
      end
      if (k <= 30) begin
        checks++;
        if (move_pulse !== ((k == 27) ? 4'b0010 : 4'b0000) || btn_held !== ((k >= 27) ? 4'b0010 : 4'b0000)) begin
          errors++;
          $display("FAIL bounce_timing k=%0d pulse=%b held=%b", k, move_pulse, btn_held);
        end
      end
    end
  endtask

  task automatic test_arbitration();
    buttons = 4'b1001;
    for (int k = 1; k <= 24; k++) begin
      if (k == 13) buttons = 4'b0;
      tick();
      checks++;
      if (move_pulse !== exp_pulse || btn_held !== exp_held) begin
        errors++;
        $display("FAIL arb_model k=%0d pulse=%b/%b held=%b/%b", k, move_pulse, exp_pulse, btn_held, exp_held);
      end
      if (k >= 7 && k <= 12) begin
        checks++;
        if (move_pulse !== ((k == 7) ? 4'b0001 : 4'b0000) || btn_held !== 4'b1001) begin
          errors++;
          $display("FAIL arb_timing k=%0d pulse=%b held=%b", k, move_pulse, btn_held);
        end
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    buttons = 4'b1000;
    for (int k = 1; k <= 35; k++) begin
      tick();
      checks++;
      if (move_pulse !== exp_pulse || btn_held !== exp_held) begin
        errors++;
        $display("FAIL pre_reset_model k=%0d pulse=%b/%b held=%b/%b", k, move_pulse, exp_pulse, btn_held, exp_held);
      end
    end
    checks++;
    if (move_pulse !== 4'b1000) begin
      errors++;
      $display("FAIL pre_reset_pulse got %b expected 1000", move_pulse);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (move_pulse !== 4'b0 || btn_held !== 4'b0) begin
      errors++;
      $display("FAIL async_reset pulse=%b held=%b expected 0000/0000", move_pulse, btn_held);
    end
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 10) buttons = 4'b0;
      tick();
      checks++;
      if (move_pulse !== exp_pulse || btn_held !== exp_held || move_pulse !== ((k == 7) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL post_reset k=%0d pulse=%b/%b held=%b/%b", k, move_pulse, exp_pulse, btn_held, exp_held);
      end
    end
    repeat (8) tick();
  endtask

  task automatic test_release_bounce();
    buttons = 4'b0001;
    for (int k = 1; k <= 52; k++) begin
      if (k == 11 || k == 12 || k >= 40) buttons = 4'b0;
      else buttons = 4'b0001;
      tick();
      checks++;
      if (move_pulse !== exp_pulse || btn_held !== exp_held) begin
        errors++;
        $display("FAIL relb_model k=%0d pulse=%b/%b held=%b/%b", k, move_pulse, exp_pulse, btn_held, exp_held);
      end
      if (k <= 40) begin
        checks++;
        if (move_pulse !== ((k == 7 || k == 35) ? 4'b0001 : 4'b0000) || btn_held !== ((k >= 7) ? 4'b0001 : 4'b0000)) begin
          errors++;
          $display("FAIL relb_timing k=%0d pulse=%b held=%b", k, move_pulse, btn_held);
        end
      end
    end
  endtask

  task automatic test_random();
    int left [4];
    for (int i = 0; i < 4; i++) left[i] = $urandom_range(1, 30);
    for (int k = 1; k <= 700; k++) begin
      for (int i = 0; i < 4; i++) begin
        left[i]--;
        if (left[i] <= 0) begin
          buttons[i] = ~buttons[i];
          left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
        end
      end
      if (k > 680) buttons = 4'b0;
      tick();
      checks++;
      if (move_pulse !== exp_pulse || btn_held !== exp_held || $countones(move_pulse) > 1) begin
        errors++;
        $display("FAIL random k=%0d pulse=%b/%b held=%b/%b", k, move_pulse, exp_pulse, btn_held, exp_held);
      end
    end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_bounce();
    test_arbitration();
    test_reset_mid_repeat();
    test_release_bounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
